// File: rtl/arith_pkg.sv
// Shared arithmetic library package: the FSM state encoding and the default
// operand width used by the serial subtractor.
package arith_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} sub_state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with bo as the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: diff = (a - b) mod 2^WIDTH, computed LSB first over
// WIDTH cycles with one full_subtractor cell and a borrow flip-flop.
// Operands arrive on a valid/ready handshake. The result is held on a
// valid/ready output until it is consumed.
// Optional build macro SUB_OVF_EN adds the ovf port (signed overflow) and
// the register that keeps the captured operand sign bits.
module serial_subtractor4
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the low WIDTH-1 result bits. The final bit goes straight into diff.
  logic [WIDTH-2:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d_bit;
  logic             br_nxt;
`ifdef SUB_OVF_EN
  // {a sign, b sign} captured at accept time.
  logic [1:0]       sign_r;
`endif

  full_subtractor u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (br),
    .d   (d_bit),
    .bo  (br_nxt)
  );

  // Control FSM and serial datapath: accept, shift one bit per cycle, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      br        <= 1'b0;
`ifdef SUB_OVF_EN
      ovf       <= 1'b0;
      sign_r    <= 2'b00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
`ifdef SUB_OVF_EN
            sign_r   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end
        end

        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= (WIDTH-1)'({d_bit, res_sr} >> 1);
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff      <= {d_bit, res_sr};
            bout      <= br_nxt;
            out_valid <= 1'b1;
            state     <= S_HOLD;
`ifdef SUB_OVF_EN
            // Overflow when the operand signs differ and the result sign
            // differs from the minuend sign; d_bit is the result MSB.
            ovf       <= (sign_r[1] ^ sign_r[0]) & (sign_r[1] ^ d_bit);
`endif
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Testbench for serial_subtractor4: directed checks on a WIDTH=4 instance,
// then a random soak that drives a WIDTH=4 and a WIDTH=8 instance in lockstep
// and checks both against a scoreboard built with plain integer arithmetic.
module tb_serial_subtractor4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  logic       in_ready4, out_valid4, bout4;
  logic [3:0] diff4;
  logic       in_ready8, out_valid8, bout8;
  logic [7:0] diff8;
`ifdef SUB_OVF_EN
  logic       ovf4, ovf8;
`endif

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   accepts4 = 0, outs4 = 0, accepts8 = 0, outs8 = 0;

  always #5 clk = ~clk;

  serial_subtractor4 #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .a         (a[3:0]),
    .b         (b[3:0]),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .diff      (diff4),
    .bout      (bout4)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  serial_subtractor4 #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .a         (a),
    .b         (b),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .diff      (diff8),
    .bout      (bout8)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: modular difference, unsigned borrow, and signed range overflow.
  function automatic exp_t model(input int av, input int bv, input int w);
    exp_t e;
    int   m  = 1 << w;
    int   sa = (av >= m / 2) ? av - m : av;
    int   sb = (bv >= m / 2) ? bv - m : bv;
    int   sd = sa - sb;
    e.d  = 8'((av - bv + m) % m);
    e.bo = (av < bv);
    e.ov = (sd > m / 2 - 1) || (sd < -(m / 2));
    return e;
  endfunction

  // One clock: scoreboard sees the handshakes at the falling edge, then the
  // rising edge happens and stimulus may change 1 time unit later.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q4.delete();
      q8.delete();
    end else begin
      if (out_valid4 && out_ready) begin
        chk("sb4_spurious", q4.size() > 0, 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("sb4_diff", diff4, e.d);
          chk("sb4_bout", bout4, e.bo);
`ifdef SUB_OVF_EN
          chk("sb4_ovf", ovf4, e.ov);
`endif
          outs4++;
        end
      end
      if (out_valid8 && out_ready) begin
        chk("sb8_spurious", q8.size() > 0, 1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("sb8_diff", diff8, e.d);
          chk("sb8_bout", bout8, e.bo);
`ifdef SUB_OVF_EN
          chk("sb8_ovf", ovf8, e.ov);
`endif
          outs8++;
        end
      end
      if (in_valid && in_ready4) begin
        q4.push_back(model(int'(a[3:0]), int'(b[3:0]), 4));
        accepts4++;
      end
      if (in_valid && in_ready8) begin
        q8.push_back(model(int'(a), int'(b), 8));
        accepts8++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [3:0] ed, input logic eb, input string tag);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid4; i++) step();
    chk({tag, "_valid"}, out_valid4, 1);
    chk({tag, "_diff"}, diff4, ed);
    chk({tag, "_bout"}, bout4, eb);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid4, 0);
  endtask

  initial begin
    int cyc;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_diff", diff4, 0);
    chk("rst_bout", bout4, 0);
    rst = 1'b0;
    step();

    // Exact latency: accept edge k, out_valid after edge k+4
    a = 8'd9; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_in_ready_run", in_ready4, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lat_early_valid", out_valid4, 0);
    end
    step();
    chk("lat_valid", out_valid4, 1);
    chk("lat_diff", diff4, 4'h6);
    chk("lat_bout", bout4, 0);
    step();
    chk("lat_drop", out_valid4, 0);
    chk("lat_in_ready_idle", in_ready4, 1);
    out_ready = 1'b0;

    do_op(8'd3,  8'd9,  4'hA, 1'b1, "a3b9");
    do_op(8'd0,  8'd0,  4'h0, 1'b0, "a0b0");
    do_op(8'd15, 8'd15, 4'h0, 1'b0, "a15b15");
    do_op(8'd0,  8'd1,  4'hF, 1'b1, "a0b1");

    // Back-pressure in HOLD with a competing operand offer
    a = 8'd9; b = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid4; i++) step();
    chk("bp_valid", out_valid4, 1);
    a = 8'd5; b = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_valid", out_valid4, 1);
      chk("bp_hold_diff", diff4, 4'h6);
      chk("bp_hold_bout", bout4, 0);
      chk("bp_hold_in_ready", in_ready4, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid4, 0);
    chk("bp_release_in_ready", in_ready4, 1);
    step();
    in_valid = 1'b0;
    chk("bp_second_accepted", in_ready4, 0);
    for (int i = 0; i < 20 && !out_valid4; i++) step();
    chk("bp_second_valid", out_valid4, 1);
    chk("bp_second_diff", diff4, 4'h3);
    step();
    out_ready = 1'b0;

    // Reset two cycles after accepting 12 - 4
    a = 8'd12; b = 8'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready4, 1);
    chk("abort_out_valid", out_valid4, 0);
    chk("abort_diff", diff4, 0);
    chk("abort_bout", bout4, 0);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid4) seen++;
    end
    chk("abort_no_result", seen, 0);
    out_ready = 1'b0;

`ifdef SUB_OVF_EN
    do_op(8'h7, 8'h8, 4'hF, 1'b1, "ovf_7m8");
    chk("ovf_7m8_ovf", ovf4, 1);
    do_op(8'h5, 8'h2, 4'h3, 1'b0, "ovf_5m2");
    chk("ovf_5m2_ovf", ovf4, 0);
`endif

    // Random soak on both widths against the scoreboard
    accepts4 = 0; outs4 = 0; accepts8 = 0; outs8 = 0;
    cyc = 0;
    while (accepts4 < 1000 && cyc < 30000) begin
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("soak_reached_1000", accepts4 >= 1000, 1);
    chk("soak_q4_empty", q4.size(), 0);
    chk("soak_q8_empty", q8.size(), 0);
    chk("soak_count4", outs4, accepts4);
    chk("soak_count8", outs8, accepts8);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
